// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: counts synchronised reference and feedback edges per window and
// watches the filter magnitude. Lock is declared after LOCK_WINS consecutive good windows.
// state | meaning: IDLE disabled, counters held | ACQUIRE counting good windows | LOCKED lock asserted
module adpll_lock_detect #(
    parameter int WIN_EDGES = 32,
    parameter int FREQ_TOL  = 1,
    parameter int PHASE_TOL = 4,
    parameter int LOCK_WINS = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_ref,
    input  logic             fb_clk,
    input  logic [4:0]       dout,
    input  logic             sign,
    output logic             lock,
    output logic             lock_lost,
    output logic [CNT_W-1:0] freq_err,
    output logic [1:0]       state
);
    localparam int DW     = CNT_W + 2;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);

    localparam logic [CNT_W-1:0]     REF_LAST  = CNT_W'(WIN_EDGES - 1);
    localparam logic [CNT_W-1:0]     FB_MAX    = {CNT_W{1'b1}};
    localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0]    GOOD_LAST = GOOD_W'(LOCK_WINS - 1);
    localparam logic signed [DW-1:0] WIN_S     = DW'(WIN_EDGES);
    localparam logic signed [DW-1:0] TOL_S     = DW'(FREQ_TOL);
    localparam logic signed [DW-1:0] ERR_MAX   = DW'(2 ** (CNT_W - 1) - 1);
    localparam logic signed [DW-1:0] ERR_MIN   = DW'(-(2 ** (CNT_W - 1)));
    localparam logic [CNT_W-1:0]     ERR_NEG   = {1'b1, {(CNT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    state_t st;

    logic ref_s1, ref_s2, ref_d;
    logic fb_s1, fb_s2, fb_d;
    logic ref_rise, fb_rise;

    logic [CNT_W-1:0]  ref_cnt, fb_cnt, fb_final;
    logic [WD_W-1:0]   wd;
    logic [GOOD_W-1:0] good_cnt;
    logic              phase_bad, phase_final;

    logic signed [DW-1:0] diff, diff_abs;
    logic [CNT_W-1:0]     err_sat;
    logic                 win_close, wd_expire, any_close, close_good;

    logic unused_sign;
    assign unused_sign = sign;

    assign ref_rise = ref_s2 & ~ref_d;
    assign fb_rise  = fb_s2 & ~fb_d;

    // Values as they stand including this cycle, so a close cycle sees its own edge and dout.
    assign fb_final    = (fb_rise && fb_cnt != FB_MAX) ? fb_cnt + CNT_W'(1) : fb_cnt;
    assign phase_final = phase_bad | (dout > 5'(PHASE_TOL));
    assign diff        = $signed({2'b00, fb_final}) - WIN_S;
    assign diff_abs    = diff[DW-1] ? -diff : diff;

    always_comb begin
        err_sat = diff[CNT_W-1:0];
        if (diff > ERR_MAX)
            err_sat = ERR_MAX[CNT_W-1:0];
        else if (diff < ERR_MIN)
            err_sat = ERR_MIN[CNT_W-1:0];
    end

    assign win_close  = ref_rise && (ref_cnt == REF_LAST);
    assign wd_expire  = !ref_rise && (wd == WD_LAST);
    assign any_close  = win_close || wd_expire;
    assign close_good = win_close && (diff_abs <= TOL_S) && !phase_final && (fb_final != FB_MAX);

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            ref_s1    <= 1'b0;
            ref_s2    <= 1'b0;
            ref_d     <= 1'b0;
            fb_s1     <= 1'b0;
            fb_s2     <= 1'b0;
            fb_d      <= 1'b0;
            ref_cnt   <= '0;
            fb_cnt    <= '0;
            wd        <= '0;
            good_cnt  <= '0;
            phase_bad <= 1'b0;
            freq_err  <= '0;
            lock      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            ref_s1    <= clk_ref;
            ref_s2    <= ref_s1;
            ref_d     <= ref_s2;
            fb_s1     <= fb_clk;
            fb_s2     <= fb_s1;
            fb_d      <= fb_s2;
            lock_lost <= 1'b0;

            if (!en || st == IDLE) begin
                st        <= en ? ACQUIRE : IDLE;
                lock      <= 1'b0;
                ref_cnt   <= '0;
                fb_cnt    <= '0;
                wd        <= '0;
                good_cnt  <= '0;
                phase_bad <= 1'b0;
            end else if (any_close) begin
                ref_cnt   <= '0;
                fb_cnt    <= '0;
                wd        <= '0;
                phase_bad <= 1'b0;
                freq_err  <= win_close ? err_sat : ERR_NEG;
                if (close_good) begin
                    if (st == ACQUIRE) begin
                        if (good_cnt == GOOD_LAST) begin
                            st       <= LOCKED;
                            lock     <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                end else begin
                    good_cnt <= '0;
                    if (st == LOCKED) begin
                        st        <= ACQUIRE;
                        lock      <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
            end else begin
                if (ref_rise)
                    ref_cnt <= ref_cnt + CNT_W'(1);
                fb_cnt    <= fb_final;
                phase_bad <= phase_final;
                wd        <= ref_rise ? '0 : wd + WD_W'(1);
            end
        end
    end
endmodule

// File: doc/adpll_lock_detect.md
Name: adpll_lock_detect

Overview:
- Lock detector sitting downstream of adpll_top. It consumes the reference clock, the feedback clock and the filter output dout/sign.
- It counts reference and feedback edges over fixed windows and checks filter-output magnitude.
- It asserts lock after a run of consecutive good windows, and exposes lock status, state and the last frequency error to the top-level wrapper.

Parameters:
- WIN_EDGES, 32, reference rising edges per measurement window (>=2).
- FREQ_TOL, 1, max allowed |fb edges - WIN_EDGES| per window.
- PHASE_TOL, 4, max allowed dout magnitude (sign ignored) on any cycle of a window.
- LOCK_WINS, 4, consecutive good windows required to declare lock (>=1).
- TIMEOUT, 255, clk cycles without a reference edge before a forced bad window.
- CNT_W, 8, width of edge counters and of freq_err.

Ports:
- clk  in  1  sampling clock (50 MHz).
- rst  in  1  synchronous active-high reset.
- en  in  1  detector enable; 0 holds block in IDLE.
- clk_ref  in  1  asynchronous reference clock.
- fb_clk  in  1  asynchronous feedback (divided DCO) clock.
- dout  in  5  filter output magnitude.
- sign  in  1  filter output sign (not used for checks).
- lock  out  1  registered lock indication.
- lock_lost  out  1  one-cycle pulse on LOCKED -> ACQUIRE.
- freq_err  out  CNT_W  signed (fb count - WIN_EDGES) of last closed window.
- state  out  2  00 IDLE, 01 ACQUIRE, 10 LOCKED.

Behaviour:
- Reset (sync, priority over all other inputs):
  - All registers go to 0, including sync flops, counters, freq_err, lock, lock_lost and state (IDLE).
  - Effect is visible the cycle after rst is sampled high.
- Input synchronisation:
  - clk_ref and fb_clk each pass through a 2-flop synchroniser, then an edge flop.
  - ref_rise / fb_rise = 1-cycle pulse when the synced value goes 0->1.
  - Latency is 3 clk from input transition to pulse.
- Window counting (ACQUIRE/LOCKED only):
  - ref_cnt counts ref_rise. fb_cnt counts fb_rise and saturates at 2^CNT_W-1.
  - Window closes on the cycle with ref_rise while ref_cnt == WIN_EDGES-1.
  - A fb_rise in the close cycle counts in the closing window.
  - Both counters become 0 the next cycle.
- Phase flag:
  - phase_bad sets on any window cycle with dout > PHASE_TOL; the close cycle is included.
  - Clears when the window restarts.
- Window evaluation at close:
  - diff = fb_cnt_final - WIN_EDGES.
  - freq_err <= diff, saturated to the signed CNT_W range.
  - good = (|diff| <= FREQ_TOL) and !phase_bad and fb_cnt not saturated.
- Timeout:
  - wd counter counts clk cycles and clears on every ref_rise.
  - When wd reaches TIMEOUT: forced bad window close, freq_err <= most-negative value (0x80 for CNT_W=8), all counters cleared.
- FSM:
  - IDLE: counters, wd and good_cnt held 0; lock=0. en=1 -> ACQUIRE next cycle.
  - ACQUIRE: good close increments good_cnt; bad close clears it. good close with good_cnt == LOCK_WINS-1 -> LOCKED.
  - LOCKED: good close stays LOCKED. Bad close (including timeout) -> ACQUIRE with good_cnt=0.
  - Any state with en=0 -> IDLE next cycle, lock=0, no lock_lost pulse; freq_err holds its value.
- Output timing:
  - lock = (state == LOCKED), registered; it rises/falls the cycle after the deciding close.
  - lock_lost is high exactly one cycle, coincident with the lock fall on a bad close from LOCKED.
- Boundary conditions:
  - A ref_rise and fb_rise in the same cycle both count.
  - A timeout in the same cycle as a ref_rise cannot occur (ref_rise clears wd first).
  - en rising mid-stream starts a fresh window from 0; the first partial ref period counts as a normal edge interval.
  - sign is ignored.

Test Plan:
- Lock acquire: rst 2 cycles, en=1; ref and fb both period 20 clk, in phase; dout=2 -> freq_err=0 at each close; lock rises the cycle after the 4th close (~2560 cycles after the first ref edge); lock_lost never pulses.
- Frequency error: ref period 20, fb period 10 -> freq_err=+32 (0x20) at each close; state stays 01; lock stays 0. Then fb period 40 -> freq_err=-16 (0xF0).
- Phase loss: locked as in scenario 1; drive dout=5, sign=1 for one cycle mid-window -> at that window's close, lock 1->0, lock_lost=1 for exactly one cycle, state=01; relock after 4 further good windows.
- Reference timeout: locked; stop clk_ref -> 255 cycles after the last ref_rise, freq_err=0x80, lock=0, lock_lost pulse, state=01.
- Enable/reset mid-operation:
  - en=0 while LOCKED -> next cycle state=00, lock=0, no lock_lost, freq_err unchanged.
  - rst=1 mid-window -> next cycle all outputs 0; re-acquire from scratch.
- Tolerance edge: fb gives exactly 33 edges per 32-edge window -> freq_err=+1, window good, lock after 4 windows; 34 edges -> freq_err=+2, never locks.
